// File: rtl/fetch_unit.sv
// MIPS instruction fetch: owns pc, fetches one word at a time over imem req/ack, holds it for decode.
// Fetch latency >= 1 cycle (ack may arrive on the first req cycle); waits in HOLD until advance.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          W_CNT    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic [1:0]       pc_src,
    input  logic [25:0]      jaddr,
    input  logic [15:0]      imm,
    input  logic             br_taken,
    input  logic [31:0]      rs_val,
    input  logic             advance,
    output logic             fault,
    output logic [W_CNT-1:0] retired
);

    localparam logic [1:0] PC_SRC_NEXT = 2'd0;
    localparam logic [1:0] PC_SRC_JUMP = 2'd1;
    localparam logic [1:0] PC_SRC_BRCH = 2'd2;
    localparam logic [1:0] PC_SRC_REGF = 2'd3;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        misaligned;
    logic        take_inst;
    logic        take_adv;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign br_off    = {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_SRC_NEXT: next_pc = pc_plus4;
            PC_SRC_JUMP: next_pc = {pc_plus4[31:28], jaddr, 2'b00};
            PC_SRC_BRCH: next_pc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            PC_SRC_REGF: next_pc = rs_val;
            default:     next_pc = pc_plus4;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        take_inst  = 1'b0;
        take_adv   = 1'b0;
        case (state)
            S_RST: state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    take_inst = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (advance) begin
                    take_adv  = 1'b1;
                    state_nxt = misaligned ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_RST;
        endcase
    end

    // A misaligned target still counts as retired; pc freezes on the faulting instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RST;
            pc      <= RESET_PC;
            inst    <= 32'h0;
            fault   <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (take_inst) begin
                inst <= imem_rdata;
            end
            if (take_adv) begin
                retired <= retired + W_CNT'(1);
                if (misaligned) begin
                    fault <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test-plan steps plus randomized traffic, checked every cycle against a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_src;
    logic [25:0] jaddr;
    logic [15:0] imm;
    logic        br_taken;
    logic [31:0] rs_val;
    logic        advance;
    logic        fault;
    logic [31:0] retired;

    fetch_unit #(.RESET_PC(32'h0000_0000), .W_CNT(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
        .pc_src(pc_src), .jaddr(jaddr), .imm(imm), .br_taken(br_taken), .rs_val(rs_val),
        .advance(advance), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] NEXT = 2'd0, JUMP = 2'd1, BRCH = 2'd2, REGF = 2'd3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase is 0=reset, 1=fetching, 2=holding, 3=faulted.
    int          m_phase;
    logic [31:0] m_pc, m_inst, m_ret;
    logic        m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        case (pc_src)
            JUMP:    return (p4 & 32'hF000_0000) | (32'(jaddr) * 32'd4);
            BRCH:    return br_taken ? p4 + 32'(int'($signed(imm)) * 4) : p4;
            REGF:    return rs_val;
            default: return p4;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        if (rst) begin
            m_phase = 0; m_pc = 32'h0; m_inst = 32'h0; m_fault = 1'b0; m_ret = 32'h0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack) begin
                m_inst  = imem_rdata;
                m_phase = 2;
            end
        end else if (m_phase == 2 && advance) begin
            tgt   = model_target();
            m_ret = m_ret + 32'd1;
            if (tgt % 4 != 0) begin
                m_fault = 1'b1;
                m_phase = 3;
            end else begin
                m_pc    = tgt;
                m_phase = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_req",   32'(imem_req),   32'(m_phase == 1));
        chk("imem_addr",  imem_addr,       m_pc);
        chk("inst",       inst,            m_inst);
        chk("inst_valid", 32'(inst_valid), 32'(m_phase == 2));
        chk("pc",         pc,              m_pc);
        chk("pc_plus4",   pc_plus4,        m_pc + 32'd4);
        chk("fault",      32'(fault),      32'(m_fault));
        chk("retired",    retired,         m_ret);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_fetch(input logic [31:0] data);
        imem_ack = 1'b1; imem_rdata = data;
        cycle();
        imem_ack = 1'b0;
    endtask

    task automatic do_adv(input logic [1:0] src, input logic [25:0] j, input logic [15:0] i,
                          input logic br, input logic [31:0] rs);
        pc_src = src; jaddr = j; imm = i; br_taken = br; rs_val = rs; advance = 1'b1;
        cycle();
        advance = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_rdata = 32'h0; imem_ack = 1'b0; pc_src = NEXT; jaddr = '0;
        imm = '0; br_taken = 1'b0; rs_val = 32'h0; advance = 1'b0;
        m_phase = 0; m_pc = 0; m_inst = 0; m_fault = 0; m_ret = 0;

        // Reset then first fetch acked on the second request cycle
        cycle(); cycle();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_pc", pc, 32'h0);
        rst = 1'b0;
        cycle();
        chk("fetch1_req", 32'(imem_req), 32'h1);
        chk("fetch1_addr", imem_addr, 32'h0);
        cycle();
        chk("fetch2_addr", imem_addr, 32'h0);
        do_fetch(32'h2008_0005);
        chk("first_inst", inst, 32'h2008_0005);
        chk("first_valid", 32'(inst_valid), 32'h1);

        // Sequential advance, then advance held while fetching is ignored
        do_adv(NEXT, '0, '0, 1'b0, 32'h0);
        chk("seq_pc", pc, 32'h4);
        chk("seq_ret", retired, 32'h1);
        chk("seq_req", 32'(imem_req), 32'h1);
        advance = 1'b1;
        repeat (3) cycle();
        advance = 1'b0;
        chk("fetch_adv_ignored", retired, 32'h1);
        do_fetch(32'h1111_1111);

        // Jump
        do_adv(REGF, '0, '0, 1'b0, 32'h10); do_fetch(32'h0800_0040);
        do_adv(JUMP, 26'h000_0040, '0, 1'b0, 32'h0);
        chk("jump_pc", pc, 32'h100);
        do_fetch(32'h2222_2222);

        // Branch taken and not taken with a negative offset
        do_adv(REGF, '0, '0, 1'b0, 32'h20); do_fetch(32'h1000_FFFC);
        do_adv(BRCH, '0, 16'hFFFC, 1'b1, 32'h0);
        chk("br_taken_pc", pc, 32'h14);
        do_fetch(32'h3333_3333);
        do_adv(REGF, '0, '0, 1'b0, 32'h20); do_fetch(32'h1000_FFFC);
        do_adv(BRCH, '0, 16'hFFFC, 1'b0, 32'h0);
        chk("br_not_taken_pc", pc, 32'h24);
        do_fetch(32'h4444_4444);

        // Register jump, then a misaligned register target faults
        do_adv(REGF, '0, '0, 1'b0, 32'h80);
        chk("regf_pc", pc, 32'h80);
        do_fetch(32'h0000_0008);
        do_adv(REGF, '0, '0, 1'b0, 32'h82);
        chk("fault_set", 32'(fault), 32'h1);
        chk("fault_pc", pc, 32'h80);
        imem_ack = 1'b1;
        repeat (10) begin
            cycle();
            chk("fault_no_req", 32'(imem_req), 32'h0);
        end
        imem_ack = 1'b0;
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("fault_cleared", 32'(fault), 32'h0);

        // Reset mid-fetch; ack arriving during the reset state is ignored
        cycle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("midrst_req", 32'(imem_req), 32'h0);
        chk("midrst_inst", inst, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        imem_ack = 1'b0;
        chk("late_ack_inst", inst, 32'h0);
        chk("late_ack_valid", 32'(inst_valid), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 59) == 0);
            imem_ack   = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            advance    = $urandom_range(0, 1) == 1;
            pc_src     = 2'($urandom_range(0, 3));
            jaddr      = 26'($urandom);
            imm        = 16'($urandom);
            br_taken   = $urandom_range(0, 1) == 1;
            rs_val     = $urandom;
            if ($urandom_range(0, 7) != 0) rs_val[1:0] = 2'b00;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder in the MIPS core.
- Owns the program counter, issues requests to instruction memory with a req/ack handshake, and holds the fetched word stable on `inst` for the decoder.
- Computes the next PC from the decoder's pc_src selection, then advances when the datapath signals the instruction has retired.
- Multi-cycle: one instruction is in flight at a time.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- W_CNT, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction memory request.
- imem_addr  out  `W_CPU  byte address of the request; always equals pc.
- imem_rdata  in  `W_CPU  instruction word; valid only when imem_ack=1.
- imem_ack  in  1  memory has returned rdata; meaningful only while imem_req=1.
- inst  out  `W_CPU  latched instruction word, to the decoder.
- inst_valid  out  1  inst holds a fetched, not-yet-retired instruction.
- pc  out  `W_CPU  address of inst.
- pc_plus4  out  `W_CPU  pc+4, combinational.
- pc_src  in  `W_PC_SRC  next-PC select from the decoder: PC_SRC_NEXT, PC_SRC_JUMP, PC_SRC_BRCH or PC_SRC_REGF.
- jaddr  in  `W_JADDR  26-bit jump field.
- imm  in  `W_IMM  16-bit branch offset field.
- br_taken  in  1  branch condition result from the ALU.
- rs_val  in  `W_CPU  register value, used as the jr target.
- advance  in  1  current instruction retired; load the next PC.
- fault  out  1  sticky misaligned-target flag.
- retired  out  W_CNT  count of accepted advances.

Behaviour:
- Reset is synchronous; every clk edge with rst=1 forces:
  - pc=RESET_PC, inst=32'h0 (nop), inst_valid=0, imem_req=0, fault=0, retired=0.
  - State RST.
  - rst overrides all other inputs, including an in-flight request; no ack-pending bookkeeping survives reset.
- States: RST, FETCH, HOLD, FAULT.
- RST:
  - imem_req=0.
  - Next edge with rst=0 goes to FETCH.
- FETCH:
  - imem_req=1 combinationally; imem_addr=pc.
  - On an edge with imem_ack=1: inst<=imem_rdata, inst_valid<=1, state<=HOLD.
  - ack may arrive in the same cycle req first rises, so the minimum fetch latency is 1 cycle.
  - advance is ignored in FETCH.
- HOLD:
  - imem_req=0; inst and pc are stable.
  - imem_ack is ignored.
  - On an edge with advance=1:
    - pc<=next_pc; inst_valid<=0; retired<=retired+1 (wraps modulo 2^W_CNT).
    - state<=FETCH.
    - inst keeps its old value until the next ack.
- next_pc, combinational, all arithmetic modulo 2^32:
  - PC_SRC_NEXT: pc_plus4.
  - PC_SRC_JUMP: {pc_plus4[31:28], jaddr, 2'b00}.
  - PC_SRC_BRCH: if br_taken, pc_plus4 + (sign_extend(imm) << 2); otherwise pc_plus4.
  - PC_SRC_REGF: rs_val.
  - Any other encoding: pc_plus4.
- Misalignment:
  - If advance=1 in HOLD and next_pc[1:0]!=0: pc is not updated, fault<=1, retired still increments, state<=FAULT.
  - FAULT: imem_req=0 and inst_valid=0; only rst exits.
- Invariants:
  - imem_addr never changes while imem_req=1.
  - inst_valid=1 only in HOLD.

Test Plan:
- Reset → first fetch: rst high 2 cycles, then low; memory acks on the 2nd req cycle with 32'h2008_0005 → imem_addr=0 for both req cycles, inst=32'h2008_0005, inst_valid=1, pc=0.
- Sequential advance: in HOLD with pc=0, pc_src=NEXT, pulse advance → pc=4, inst_valid=0, imem_req=1 next cycle, retired=1. Hold advance=1 for 3 extra cycles in FETCH → retired stays 1.
- Jump: pc=32'h0000_0010, pc_src=JUMP, jaddr=26'h000_0040, advance → pc=32'h0000_0100.
- Branch: pc=32'h0000_0020, pc_src=BRCH, imm=16'hFFFC:
  - br_taken=1 → pc=32'h0000_0014.
  - br_taken=0 → pc=32'h0000_0024.
- Register jump and fault: pc_src=REGF, rs_val=32'h0000_0080 → pc=32'h80. Then rs_val=32'h0000_0082 → fault=1, pc unchanged at 32'h80, imem_req stays 0 for 10 cycles; rst clears fault.
- Reset mid-fetch: assert rst while in FETCH with no ack → next cycle imem_req=0, pc=RESET_PC, inst=0. A late ack arriving after reset is ignored.
